// File: rtl/lcd_sched_pkg.sv
// Shared types and LCD command bytes for the two-requester line scheduler.
package lcd_sched_pkg;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_INIT,
    ST_IDLE,
    ST_ADDR,
    ST_CHAR,
    ST_ACK
  } state_t;

  typedef enum logic [1:0] {
    XS_IDLE,
    XS_WAIT,
    XS_GAP
  } xfer_state_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE0    = 8'h80;
  localparam logic [7:0] CMD_LINE1    = 8'hC0;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

  // Column 0 lives in the top byte of the 128-bit line buffer.
  function automatic logic [7:0] text_char(input logic [127:0] text, input logic [3:0] col);
    logic [127:0] w_shifted;
    w_shifted = text << {col, 3'b000};
    return w_shifted[127:120];
  endfunction

endpackage

// File: rtl/lcd_byte_xfer.sv
// Single-byte start/done handshake to the LCD controller followed by a fixed idle gap.
module lcd_byte_xfer
  import lcd_sched_pkg::*;
#(
  parameter int DLY_CYCLES = 262143
) (
  input  logic       iCLK,
  input  logic       reset,
  input  logic       i_send,
  input  logic [7:0] i_data,
  input  logic       i_rs,
  input  logic       i_lcd_done,
  output logic       o_lcd_start,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_byte_ok
);

  localparam int GW = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(DLY_CYCLES - 1);

  xfer_state_t   r_state, w_next;
  logic [GW-1:0] r_gap_cnt;
  logic          r_start, r_rs;
  logic [7:0]    r_data;
  logic          w_accept, w_done, w_gap_end;

  // lcd_done only counts while lcd_start is being held high.
  assign w_accept  = (r_state == XS_IDLE) && i_send;
  assign w_done    = (r_state == XS_WAIT) && i_lcd_done;
  assign w_gap_end = (DLY_CYCLES == 0) ? w_done
                                       : ((r_state == XS_GAP) && (r_gap_cnt == GAP_LAST));

  // NOTE: every output is assigned a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      XS_IDLE: if (w_accept) w_next = XS_WAIT;
      XS_WAIT: if (w_done) w_next = (DLY_CYCLES == 0) ? XS_IDLE : XS_GAP;
      XS_GAP:  if (w_gap_end) w_next = XS_IDLE;
      default: w_next = XS_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (reset) r_state <= XS_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge iCLK) begin
    if (reset) begin
      r_start   <= 1'b0;
      r_data    <= '0;
      r_rs      <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_start <= 1'b1;
        r_data  <= i_data;
        r_rs    <= i_rs;
      end else if (w_done) begin
        r_start <= 1'b0;
      end
      if (w_done)                  r_gap_cnt <= '0;
      else if (r_state == XS_GAP)  r_gap_cnt <= r_gap_cnt + 1'b1;
    end
  end

  // byte_ok is combinational so the caller can present the next byte without a bubble.
  assign o_byte_ok   = w_gap_end;
  assign o_lcd_start = r_start;
  assign o_lcd_data  = r_data;
  assign o_lcd_rs    = r_rs;

endmodule

// File: rtl/lcd_line_scheduler.sv
// Powers up and initialises a 2x16 character LCD, then writes whole lines for two
// round-robin requesters, acknowledging each line once its 16 characters are sent.
module lcd_line_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int INIT_WAIT  = 1048575,
  parameter int DLY_CYCLES = 262143
) (
  input  logic         iCLK,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic         line0,
  input  logic         line1,
  input  logic [127:0] text0,
  input  logic [127:0] text1,
  output logic         ack0,
  output logic         ack1,
  output logic [7:0]   lcd_data,
  output logic         lcd_rs,
  output logic         lcd_start,
  input  logic         lcd_done,
  output logic         init_done,
  output logic         busy
);

  localparam int PW = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam logic [PW-1:0] PWR_LAST = PW'(INIT_WAIT - 1);

  state_t         r_state, w_next;
  logic [PW-1:0]  r_pwr_cnt;
  logic [1:0]     r_init_idx;
  logic [3:0]     r_char_idx;
  logic [127:0]   r_text;
  logic           r_line, r_gnt, r_rr_ptr, r_init_done;
  logic           w_send, w_rs, w_grant, w_winner, w_byte_ok;
  logic [7:0]     w_data;

  // With both pending the pointer decides; it always names the requester not served last.
  assign w_winner = (req0 && req1) ? r_rr_ptr : req1;

  always_comb begin
    w_next  = r_state;
    w_send  = 1'b0;
    w_rs    = 1'b0;
    w_data  = '0;
    w_grant = 1'b0;
    case (r_state)
      ST_PWR:  if (r_pwr_cnt == PWR_LAST) w_next = ST_INIT;
      ST_INIT: begin
        w_send = 1'b1;
        w_data = init_cmd(r_init_idx);
        if (w_byte_ok && (r_init_idx == 2'd3)) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (req0 || req1) begin
          w_grant = 1'b1;
          w_next  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        w_send = 1'b1;
        w_data = r_line ? CMD_LINE1 : CMD_LINE0;
        if (w_byte_ok) w_next = ST_CHAR;
      end
      ST_CHAR: begin
        w_send = 1'b1;
        w_rs   = 1'b1;
        w_data = text_char(r_text, r_char_idx);
        if (w_byte_ok && (r_char_idx == 4'd15)) w_next = ST_ACK;
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_PWR;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (reset) r_state <= ST_PWR;
    else       r_state <= w_next;
  end

  // NOTE: the line buffer is cleared on reset so an abandoned line leaves nothing behind.
  always_ff @(posedge iCLK) begin
    if (reset) begin
      r_pwr_cnt   <= '0;
      r_init_idx  <= '0;
      r_char_idx  <= '0;
      r_text      <= '0;
      r_line      <= 1'b0;
      r_gnt       <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      if (r_state == ST_PWR) r_pwr_cnt <= r_pwr_cnt + 1'b1;
      if ((r_state == ST_INIT) && w_byte_ok) begin
        r_init_idx <= r_init_idx + 1'b1;
        if (r_init_idx == 2'd3) r_init_done <= 1'b1;
      end
      if (w_grant) begin
        r_gnt      <= w_winner;
        r_rr_ptr   <= ~w_winner;
        r_text     <= w_winner ? text1 : text0;
        r_line     <= w_winner ? line1 : line0;
        r_char_idx <= '0;
      end
      if ((r_state == ST_CHAR) && w_byte_ok && (r_char_idx != 4'd15))
        r_char_idx <= r_char_idx + 1'b1;
    end
  end

  lcd_byte_xfer #(
    .DLY_CYCLES (DLY_CYCLES)
  ) u_xfer (
    .iCLK        (iCLK),
    .reset       (reset),
    .i_send      (w_send),
    .i_data      (w_data),
    .i_rs        (w_rs),
    .i_lcd_done  (lcd_done),
    .o_lcd_start (lcd_start),
    .o_lcd_data  (lcd_data),
    .o_lcd_rs    (lcd_rs),
    .o_byte_ok   (w_byte_ok)
  );

  assign ack0      = (r_state == ST_ACK) && !r_gnt;
  assign ack1      = (r_state == ST_ACK) &&  r_gnt;
  assign busy      = (r_state != ST_IDLE);
  assign init_done = r_init_done;

endmodule

// File: tb/tb_lcd_line_scheduler.sv
// Randomised line requests checked against a transaction-level model of the LCD byte stream.
module tb_lcd_line_scheduler;

  localparam int INIT_WAIT = 8;
  localparam int DLY       = 4;

  logic         iCLK = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, line0 = 1'b0, line1 = 1'b0;
  logic [127:0] text0 = '0, text1 = '0;
  logic         ack0, ack1, lcd_rs, lcd_start, init_done, busy;
  logic [7:0]   lcd_data;
  logic         lcd_done = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  bit         ack_q[$];
  bit         exp_ack_q[$];
  int         gap_q[$];
  bit         exp_ptr;

  always #5 iCLK = ~iCLK;

  lcd_line_scheduler #(
    .INIT_WAIT  (INIT_WAIT),
    .DLY_CYCLES (DLY)
  ) dut (
    .iCLK      (iCLK),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .line0     (line0),
    .line1     (line1),
    .text0     (text0),
    .text1     (text1),
    .ack0      (ack0),
    .ack1      (ack1),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_start (lcd_start),
    .lcd_done  (lcd_done),
    .init_done (init_done),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // LCD controller: raises lcd_done on the third cycle of lcd_start.
  int done_cnt = 0;
  always @(posedge iCLK) begin
    if (lcd_start && !lcd_done) begin
      if (done_cnt == 2) lcd_done <= 1'b1;
      done_cnt <= done_cnt + 1;
    end else begin
      lcd_done <= 1'b0;
      done_cnt <= 0;
    end
  end

  // Bus monitor: records every byte, the low time before it, and every ack pulse.
  bit         prev_start = 1'b0;
  bit         has_prev = 1'b0;
  int         low_cnt = 0;
  logic [8:0] cur_byte = '0;
  always @(negedge iCLK) begin
    if (reset) begin
      prev_start = 1'b0;
      has_prev   = 1'b0;
      low_cnt    = 0;
    end else begin
      if (lcd_start && !prev_start) begin
        cur_byte = {lcd_rs, lcd_data};
        obs_q.push_back(cur_byte);
        if (has_prev) begin
          gap_q.push_back(low_cnt);
          check("gap_min", 32'(low_cnt >= DLY + 1), 1);
        end
        has_prev = 1'b1;
      end
      if (lcd_start && lcd_done) check("hold_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, cur_byte});
      low_cnt = lcd_start ? 0 : low_cnt + 1;
      if (ack0 || ack1) check("ack_exclusive", {31'd0, ack0 && ack1}, 0);
      if (ack0) ack_q.push_back(1'b0);
      if (ack1) ack_q.push_back(1'b1);
      prev_start = lcd_start;
    end
  end

  // Reference model: a served line is the row address command followed by 16 characters.
  task automatic push_line(input logic [127:0] t, input bit l);
    exp_q.push_back({1'b0, l ? 8'hC0 : 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'((t >> (8 * (15 - i))) & 128'hFF)});
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic model_grant(input bit g);
    exp_ack_q.push_back(g);
    push_line(g ? text1 : text0, g ? line1 : line0);
    exp_ptr = ~g;
  endtask

  task automatic run_acks(input int n, input bit drop_each);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < n * 1500) begin
      @(negedge iCLK);
      cyc++;
      if (ack0) begin
        got++;
        if (drop_each) begin
          req0 = 1'b0;
          text0 = {$urandom, $urandom, $urandom, $urandom};
          line0 = 1'($urandom_range(0, 1));
        end
      end
      if (ack1) begin
        got++;
        if (drop_each) begin
          req1 = 1'b0;
          text1 = {$urandom, $urandom, $urandom, $urandom};
          line1 = 1'($urandom_range(0, 1));
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("ack_count", got, n);
    repeat (20) @(negedge iCLK);
  endtask

  task automatic compare(input string tag);
    check({tag, "_nbytes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
    check({tag, "_nacks"}, ack_q.size(), exp_ack_q.size());
    for (int i = 0; i < exp_ack_q.size() && i < ack_q.size(); i++)
      check($sformatf("%s_ack%0d", tag, i), {31'd0, ack_q[i]}, {31'd0, exp_ack_q[i]});
    obs_q.delete();
    exp_q.delete();
    ack_q.delete();
    exp_ack_q.delete();
  endtask

  initial begin
    int           n;
    int           s;
    int           rises;
    bit           prev;
    logic [127:0] t_saved;
    bit           l_saved;

    // Reset values, power-up wait, init sequence; a one-cycle req1 during INIT is lost.
    repeat (3) @(negedge iCLK);
    check("rst_start", {31'd0, lcd_start}, 0);
    check("rst_data", {24'd0, lcd_data}, 0);
    check("rst_rs", {31'd0, lcd_rs}, 0);
    check("rst_acks", {30'd0, ack0, ack1}, 0);
    check("rst_init_done", {31'd0, init_done}, 0);
    check("rst_busy", {31'd0, busy}, 1);
    obs_q.delete(); ack_q.delete(); gap_q.delete();
    reset = 1'b0;
    n = 0;
    while (!lcd_start && n < 100) begin
      @(negedge iCLK);
      n++;
    end
    check("pwr_wait", 32'(n > INIT_WAIT && n <= INIT_WAIT + 2), 1);
    @(negedge iCLK) req1 = 1'b1;
    @(negedge iCLK) req1 = 1'b0;
    n = 0;
    while (!init_done && n < 300) begin
      @(negedge iCLK);
      n++;
    end
    check("init_done", {31'd0, init_done}, 1);
    check("idle_busy", {31'd0, busy}, 0);
    repeat (60) @(negedge iCLK);
    check("init_gaps", gap_q.size(), 3);
    foreach (gap_q[i]) check($sformatf("init_gap%0d", i), gap_q[i], DLY + 1);
    check("pulse_busy", {31'd0, busy}, 0);
    push_init();
    compare("init");
    exp_ptr = 1'b0;

    // Both requesters held through their acks alternate, starting with req0.
    text0 = {$urandom, $urandom, $urandom, $urandom}; line0 = 1'b0;
    text1 = {$urandom, $urandom, $urandom, $urandom}; line1 = 1'b1;
    for (int k = 0; k < 4; k++) model_grant(exp_ptr);
    check("rr_first", {31'd0, exp_ack_q[0]}, 0);
    req0 = 1'b1; req1 = 1'b1;
    run_acks(4, 1'b0);
    compare("both_held");

    // Known text on the bottom row.
    text0 = "0123456789ABCDEF"; line0 = 1'b1;
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b1, 8'(8'h30 + i)});
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b1, 8'(8'h41 + i)});
    exp_ack_q.push_back(1'b0);
    exp_ptr = 1'b1;
    req0 = 1'b1;
    run_acks(1, 1'b1);
    compare("digits");

    // text1/line1 rewritten mid-line: the latched copy must still be sent.
    text1 = {$urandom, $urandom, $urandom, $urandom}; line1 = 1'b0;
    model_grant(1'b1);
    req1 = 1'b1;
    n = 0;
    while (obs_q.size() < 6 && n < 500) begin
      @(negedge iCLK);
      n++;
    end
    text1 = ~text1; line1 = 1'b1;
    run_acks(1, 1'b1);
    compare("text_change");

    // Random single and contended rounds, each requester dropping on its own ack.
    for (int r = 0; r < 8; r++) begin
      s = $urandom_range(1, 3);
      text0 = {$urandom, $urandom, $urandom, $urandom}; line0 = 1'($urandom_range(0, 1));
      text1 = {$urandom, $urandom, $urandom, $urandom}; line1 = 1'($urandom_range(0, 1));
      if (s == 3) begin
        model_grant(exp_ptr);
        model_grant(exp_ptr);
      end else begin
        model_grant(s == 2);
      end
      @(negedge iCLK);
      req0 = s[0]; req1 = s[1];
      run_acks((s == 3) ? 2 : 1, 1'b1);
      compare($sformatf("rnd%0d", r));
    end

    // Reset during character 7 abandons the line; the held req1 is served after re-init.
    t_saved = {$urandom, $urandom, $urandom, $urandom};
    l_saved = 1'($urandom_range(0, 1));
    text1 = t_saved; line1 = l_saved;
    req1 = 1'b1;
    rises = 0; prev = lcd_start; n = 0;
    while (rises < 9 && n < 1000) begin
      @(negedge iCLK);
      n++;
      if (lcd_start && !prev) rises++;
      prev = lcd_start;
    end
    check("char7_reached", rises, 9);
    reset = 1'b1;
    @(negedge iCLK);
    check("midrst_start", {31'd0, lcd_start}, 0);
    check("midrst_busy", {31'd0, busy}, 1);
    check("midrst_init_done", {31'd0, init_done}, 0);
    check("midrst_no_ack", ack_q.size(), 0);
    obs_q.delete(); ack_q.delete(); gap_q.delete();
    @(negedge iCLK);
    reset = 1'b0;
    push_init();
    push_line(t_saved, l_saved);
    exp_ack_q.push_back(1'b1);
    run_acks(1, 1'b1);
    compare("reinit");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
